// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_set_ctrl
// Purpose  : Front end of the time/date counter. Conditions the three raw
//            push buttons (synchronise, debounce, auto-repeat), runs the
//            field-edit state machine, generates the 1 Hz advance tick and
//            issues one-cycle inc/dec commands for the selected field.
// Ports    : clk            - system clock
//            rst_n          - asynchronous active-low reset
//            butt_increase  - raw button, active-low, asynchronous
//            butt_decrease  - raw button, active-low, asynchronous
//            butt_change    - raw button, active-low, asynchronous
//            mode           - 0 time view, 1 date view (synchronous level)
//            tick_1hz       - one-cycle pulse every CLK_HZ cycles (IDLE only)
//            edit_active    - 1 while a field is being edited
//            field_sel[2:0] - 0 none,1 hour,2 min,3 sec,4 day,5 month,6 year
//            inc_pulse      - one-cycle increment for field_sel
//            dec_pulse      - one-cycle decrement for field_sel
//            blink_on       - display gate for the selected field (1 = show)
// Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
  parameter int unsigned BLINK_CYC        = 12_500_000,
  parameter int unsigned EDIT_TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  input  logic       butt_change,
  input  logic       mode,
  output logic       tick_1hz,
  output logic       edit_active,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       blink_on
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                   REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
  localparam int unsigned PS_W   = $clog2(CLK_HZ + 1);
  localparam int unsigned BL_W   = $clog2(BLINK_CYC + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYC - 1);
  localparam logic [RP_W-1:0] RP_ONE     = RP_W'(1);
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] PS_ONE     = PS_W'(1);
  localparam logic [BL_W-1:0] BL_LAST    = BL_W'(BLINK_CYC - 1);
  localparam logic [BL_W-1:0] BL_ONE     = BL_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E_HOUR  = 3'd1,
    E_MIN   = 3'd2,
    E_SEC   = 3'd3,
    E_DAY   = 3'd4,
    E_MONTH = 3'd5,
    E_YEAR  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;
  logic            tick_q, tick_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            blink_q, blink_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            mode_q;

  // Index 0 = increase, 1 = decrease, 2 = change.
  logic [2:0] raw;
  logic [2:0] sync_pressed;   // synchronised sample, 1 = pressed
  logic [2:0] level_pressed;  // debounced level, 1 = pressed
  logic [2:0] press_evt;      // released->pressed acceptance (combinational)
  logic [2:0] btn_evt;        // press or auto-repeat events
  logic       clash;
  logic       any_evt;
  logic       mode_chg;
  logic       timeout_hit;

  assign raw = {butt_change, butt_decrease, butt_increase};

  // ---------------------------------------------------------------------------
  // Synchroniser + debounce. The level only moves after DEBOUNCE_CYC equal
  // synced samples that differ from it; the press event is raised in the
  // cycle the new level is accepted, so it takes effect at the same edge.
  // ---------------------------------------------------------------------------
  generate
    for (genvar b = 0; b < 3; b++) begin : g_btn
      logic            s1_q, s2_q, lvl_q;
      logic [DB_W-1:0] cnt_q;
      logic            differ, accept;

      assign differ           = (s2_q != lvl_q);
      assign accept           = differ && (cnt_q == DB_LAST);
      assign press_evt[b]     = accept && !s2_q;
      assign sync_pressed[b]  = !s2_q;
      assign level_pressed[b] = !lvl_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_q  <= 1'b1;
          s2_q  <= 1'b1;
          lvl_q <= 1'b1;
          cnt_q <= '0;
        end else begin
          s1_q <= raw[b];
          s2_q <= s1_q;
          if (accept) begin
            lvl_q <= s2_q;
            cnt_q <= '0;
          end else if (differ) begin
            cnt_q <= cnt_q + DB_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Auto-repeat for increase/decrease. Phase 0 waits the initial delay,
  // phase 1 runs at the repeat rate. Repeats are gated by the synced sample
  // as well as the debounced level so that no extra event slips out while
  // the release is still being debounced.
  // ---------------------------------------------------------------------------
  assign clash = btn_evt[0] && btn_evt[1];

  generate
    for (genvar b = 0; b < 2; b++) begin : g_rep
      logic [RP_W-1:0] rep_cnt_q;
      logic            rep_phase_q;
      logic            rep_fire;

      assign rep_fire   = level_pressed[b] && sync_pressed[b] &&
                          (rep_cnt_q == (rep_phase_q ? RATE_LAST : DELAY_LAST));
      assign btn_evt[b] = press_evt[b] || rep_fire;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rep_cnt_q   <= '0;
          rep_phase_q <= 1'b0;
        end else if (press_evt[b] || clash || !level_pressed[b]) begin
          rep_cnt_q   <= '0;
          rep_phase_q <= 1'b0;
        end else if (rep_fire) begin
          rep_cnt_q   <= '0;
          rep_phase_q <= 1'b1;
        end else begin
          rep_cnt_q <= rep_cnt_q + RP_ONE;
        end
      end
    end
  endgenerate

  assign btn_evt[2] = press_evt[2];
  assign any_evt    = |btn_evt;
  assign mode_chg   = (mode != mode_q);

  // ---------------------------------------------------------------------------
  // Edit inactivity timeout; a zero setting removes it entirely.
  // ---------------------------------------------------------------------------
  generate
    if (EDIT_TIMEOUT_CYC > 0) begin : g_timeout_on
      localparam int unsigned     TO_W    = $clog2(EDIT_TIMEOUT_CYC + 1);
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(EDIT_TIMEOUT_CYC - 1);
      localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
      logic [TO_W-1:0] to_cnt_q;

      assign timeout_hit = (state_q != IDLE) && !any_evt && (to_cnt_q == TO_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          to_cnt_q <= '0;
        end else if ((state_q == IDLE) || any_evt || timeout_hit) begin
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_ONE;
        end
      end
    end else begin : g_timeout_off
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Field-edit FSM. Exit conditions (mode change, timeout) win over button
  // events; a change event wins over a simultaneous inc/dec.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      mode_q  <= mode;
    end
  end

  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    if (state_q == IDLE) begin
      if (btn_evt[2]) begin
        state_d = mode ? E_DAY : E_HOUR;
      end
    end else if (mode_chg || timeout_hit) begin
      state_d = IDLE;
    end else if (btn_evt[2]) begin
      case (state_q)
        E_HOUR:  state_d = E_MIN;
        E_MIN:   state_d = E_SEC;
        E_SEC:   state_d = IDLE;
        E_DAY:   state_d = E_MONTH;
        E_MONTH: state_d = E_YEAR;
        E_YEAR:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else begin
      inc_d = btn_evt[0] && !btn_evt[1];
      dec_d = btn_evt[1] && !btn_evt[0];
    end
  end

  // ---------------------------------------------------------------------------
  // 1 Hz prescaler: frozen at 0 while editing so the first tick after exit
  // lands exactly CLK_HZ cycles later. The tick is also masked on the entry
  // edge so it never coincides with edit_active.
  // ---------------------------------------------------------------------------
  always_comb begin
    ps_d   = '0;
    tick_d = 1'b0;
    if (state_q == IDLE) begin
      ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PS_ONE;
      tick_d = (ps_q == PS_LAST) && (state_d == IDLE);
    end
  end

  // Blink restarts high on every field entry/change.
  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = '0;
    if (state_d == IDLE) begin
      blink_d = 1'b0;
    end else if (state_d != state_q) begin
      blink_d = 1'b1;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_d = !blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q        <= '0;
      tick_q      <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      ps_q        <= ps_d;
      tick_q      <= tick_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign tick_1hz    = tick_q;
  assign edit_active = (state_q != IDLE);
  assign field_sel   = state_q;
  assign inc_pulse   = inc_q;
  assign dec_pulse   = dec_q;
  assign blink_on    = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_set_ctrl
// Purpose  : Directed self-checking bench for clock_set_ctrl with short
//            timing parameters. Inputs are driven and outputs sampled 1 time
//            unit after each rising edge; "cycle j" below means the sample
//            taken after the j-th edge following the stimulus change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

  logic       clk;
  logic       rst_n;
  logic       butt_increase;
  logic       butt_decrease;
  logic       butt_change;
  logic       mode;
  logic       tick_1hz;
  logic       edit_active;
  logic [2:0] field_sel;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       blink_on;

  int n_checks;
  int n_fail;

  clock_set_ctrl #(
    .CLK_HZ           (10),
    .DEBOUNCE_CYC     (4),
    .REPEAT_DELAY_CYC (20),
    .REPEAT_RATE_CYC  (5),
    .BLINK_CYC        (8),
    .EDIT_TIMEOUT_CYC (100)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .butt_increase (butt_increase),
    .butt_decrease (butt_decrease),
    .butt_change   (butt_change),
    .mode          (mode),
    .tick_1hz      (tick_1hz),
    .edit_active   (edit_active),
    .field_sel     (field_sel),
    .inc_pulse     (inc_pulse),
    .dec_pulse     (dec_pulse),
    .blink_on      (blink_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Change press long enough to be accepted (event lands at cycle 6),
  // then a gap long enough for the release to settle.
  task automatic press_change(input int hold, input int gap);
    butt_change = 1'b0;
    repeat (hold) next_cycle();
    butt_change = 1'b1;
    repeat (gap) next_cycle();
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    butt_increase = 1'b1;
    butt_decrease = 1'b1;
    butt_change   = 1'b1;
    mode          = 1'b0;

    // ---------------- reset values and free-running tick ----------------
    repeat (3) next_cycle();
    check_eq("reset_outputs", {24'd0, tick_1hz, edit_active, field_sel, inc_pulse, dec_pulse, blink_on}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      next_cycle();
      check_eq($sformatf("tick_free_c%0d", k), {31'd0, tick_1hz}, {31'd0, (k % 10) == 0});
    end

    // ---------------- bounced change press -> exactly one event ----------------
    for (int r = 0; r < 2; r++) begin
      butt_change = 1'b0;
      repeat (3) next_cycle();
      butt_change = 1'b1;
      repeat (3) next_cycle();
    end
    check_eq("bounce_no_event", {29'd0, field_sel}, 32'd0);
    butt_change = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      next_cycle();
      check_eq($sformatf("enter_field_c%0d", j), {29'd0, field_sel}, (j >= 6) ? 32'd1 : 32'd0);
      if (j >= 6) begin
        check_eq($sformatf("enter_edit_c%0d", j), {31'd0, edit_active}, 32'd1);
        check_eq($sformatf("enter_notick_c%0d", j), {31'd0, tick_1hz}, 32'd0);
        check_eq($sformatf("blink_c%0d", j), {31'd0, blink_on}, (((j - 6) / 8) % 2 == 0) ? 32'd1 : 32'd0);
      end
      if (j == 10) butt_change = 1'b1;
    end

    // ---------------- E_MIN: hold inc 40 cycles ----------------
    press_change(8, 8);
    check_eq("field_min", {29'd0, field_sel}, 32'd2);
    butt_increase = 1'b0;
    for (int j = 1; j <= 50; j++) begin
      next_cycle();
      check_eq($sformatf("repeat_c%0d", j), {30'd0, inc_pulse, dec_pulse},
               ((j == 6) || (j == 26) || (j == 31) || (j == 36) || (j == 41)) ? 32'd2 : 32'd0);
      if (j == 40) butt_increase = 1'b1;
    end
    check_eq("field_min_after_inc", {29'd0, field_sel}, 32'd2);

    // ---------------- E_SEC, exit, date edit with inc+dec together ----------------
    press_change(8, 8);
    check_eq("field_sec", {29'd0, field_sel}, 32'd3);
    press_change(8, 8);
    check_eq("exit_time_edit", {29'd0, field_sel}, 32'd0);
    mode = 1'b1;
    repeat (2) next_cycle();
    press_change(8, 8);
    check_eq("field_day", {29'd0, field_sel}, 32'd4);
    butt_increase = 1'b0;
    butt_decrease = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      next_cycle();
      check_eq($sformatf("clash_c%0d", j), {30'd0, inc_pulse, dec_pulse}, 32'd0);
      if (j == 10) begin
        butt_increase = 1'b1;
        butt_decrease = 1'b1;
      end
    end
    press_change(8, 8);
    check_eq("field_month", {29'd0, field_sel}, 32'd5);
    press_change(8, 8);
    check_eq("field_year", {29'd0, field_sel}, 32'd6);
    butt_change = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      next_cycle();
      check_eq($sformatf("exit_field_c%0d", j), {29'd0, field_sel}, (j >= 6) ? 32'd0 : 32'd6);
      check_eq($sformatf("exit_tick_c%0d", j), {31'd0, tick_1hz}, (j == 16) ? 32'd1 : 32'd0);
      if (j == 8) butt_change = 1'b1;
    end

    // ---------------- mode toggle exits edit; inactivity timeout ----------------
    press_change(8, 8);
    check_eq("field_day_again", {29'd0, field_sel}, 32'd4);
    mode = 1'b0;
    next_cycle();
    check_eq("mode_exit_field", {29'd0, field_sel}, 32'd0);
    check_eq("mode_exit_pulses", {30'd0, inc_pulse, dec_pulse}, 32'd0);
    press_change(8, 8);
    check_eq("field_hour_again", {29'd0, field_sel}, 32'd1);
    repeat (80) next_cycle();
    check_eq("timeout_not_yet", {31'd0, edit_active}, 32'd1);
    repeat (15) next_cycle();
    check_eq("timeout_exit", {31'd0, edit_active}, 32'd0);

    // ---------------- asynchronous reset mid-edit with inc held ----------------
    press_change(8, 8);
    check_eq("field_hour_pre_rst", {29'd0, field_sel}, 32'd1);
    butt_increase = 1'b0;
    repeat (3) next_cycle();
    rst_n = 1'b0;
    #2;
    check_eq("async_rst_outputs", {24'd0, tick_1hz, edit_active, field_sel, inc_pulse, dec_pulse, blink_on}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      next_cycle();
      check_eq($sformatf("post_rst_c%0d", j), {29'd0, inc_pulse, dec_pulse, edit_active}, 32'd0);
    end
    butt_increase = 1'b1;
    repeat (10) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
